// File: rtl/uart_rx_deframer_if.sv
// Bus between the Rx deframer and its environment: sample tick, Rx line, FIFO write side, flow control.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic                 Sample_En;
    logic                 Rx;
    logic                 FIFO_Full;
    logic                 RTS;
    logic                 Wr_En;
    logic [DATA_BITS-1:0] Wr_Data;
    logic [2:0]           Rx_Error;
    logic                 Rx_Busy;
    logic                 Overrun;

    modport slave (
        input  Sample_En, Rx, FIFO_Full,
        output RTS, Wr_En, Wr_Data, Rx_Error, Rx_Busy, Overrun
    );

    modport master (
        output Sample_En, Rx, FIFO_Full,
        input  RTS, Wr_En, Wr_Data, Rx_Error, Rx_Busy, Overrun
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/parity/stop checking, one FIFO write per character.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote around mid-bit.
module uart_rx_deframer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_BIT = 1,
    parameter int STOP_BITS  = 2,
    parameter int OVERSAMPLE = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    uart_rx_deframer_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE) + 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int MID_LAST = OVERSAMPLE / 2;
`else
    localparam int MID_LAST = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [CW-1:0] START_END = CW'(MID_LAST);
    localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 w_bit;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [SW-1:0]        r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_all_zero;
    logic                 r_brk_wait;
    logic                 r_wr_en;
    logic [DATA_BITS-1:0] r_wr_data;
    logic [2:0]           r_rx_err;
    logic                 r_rts;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= bus.Rx;
            r_rx_sync <= r_rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // r_hist holds the two ticks before the current one, so the vote spans mid-1 .. mid+1
    logic [1:0] r_hist;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_hist <= 2'b11;
        else if (bus.Sample_En)
            r_hist <= {r_hist[0], r_rx_sync};
    end
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_sync) | (r_hist[0] & r_rx_sync);
`else
    assign w_bit = r_rx_sync;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_idx  <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_all_zero  <= 1'b0;
            r_brk_wait  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_rx_err    <= 3'b000;
            r_rts       <= 1'b0;
        end else begin
            r_rts   <= ~bus.FIFO_Full;
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Sample_En) begin
                        // after a break, the line must go high before a new start is accepted
                        if (r_brk_wait) begin
                            if (r_rx_sync)
                                r_brk_wait <= 1'b0;
                        end else if (!r_rx_sync) begin
                            r_cnt   <= '0;
                            r_state <= START;
                        end
                    end
                end
                START: begin
                    if (bus.Sample_En) begin
                        if (r_cnt == START_END) begin
                            if (w_bit) begin
                                r_state <= IDLE;
                            end else begin
                                r_cnt       <= '0;
                                r_idx       <= IW'(DATA_BITS - 1);
                                r_par_err   <= 1'b0;
                                r_frame_err <= 1'b0;
                                r_all_zero  <= 1'b1;
                                r_state     <= DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.Sample_En) begin
                        if (r_cnt == BIT_END) begin
                            r_cnt          <= '0;
                            r_shift[r_idx] <= w_bit;
                            r_all_zero     <= r_all_zero & ~w_bit;
                            if (r_idx == '0) begin
                                r_stop_idx <= '0;
                                r_state    <= (PARITY_BIT != 0) ? PARITY : STOP;
                            end else begin
                                r_idx <= r_idx - 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.Sample_En) begin
                        if (r_cnt == BIT_END) begin
                            r_cnt      <= '0;
                            r_par_err  <= (^r_shift) != w_bit;
                            r_all_zero <= r_all_zero & ~w_bit;
                            r_stop_idx <= '0;
                            r_state    <= STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bus.Sample_En) begin
                        if (r_cnt == BIT_END) begin
                            r_cnt <= '0;
                            if (r_stop_idx == SW'(STOP_BITS - 1)) begin
                                // the last stop sample is folded in directly so the write lands next cycle
                                r_wr_en   <= 1'b1;
                                r_wr_data <= r_shift;
                                if (r_all_zero & ~w_bit) begin
                                    r_rx_err   <= 3'b001;
                                    r_brk_wait <= 1'b1;
                                end else begin
                                    r_rx_err <= {r_frame_err | ~w_bit, r_par_err, 1'b0};
                                end
                                r_state <= DONE;
                            end else begin
                                r_frame_err <= r_frame_err | ~w_bit;
                                r_all_zero  <= r_all_zero & ~w_bit;
                                r_stop_idx  <= r_stop_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.RTS      = r_rts;
    assign bus.Wr_En    = r_wr_en;
    assign bus.Wr_Data  = r_wr_data;
    assign bus.Rx_Error = r_rx_err;
    assign bus.Rx_Busy  = (r_state != IDLE);
    assign bus.Overrun  = r_wr_en & bus.FIFO_Full;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: stimulus pushes expected writes, a negedge monitor pops and checks them.
module tb_uart_rx_deframer;
    localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 188;
`else
    localparam int LAT = 187;
`endif

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    uart_rx_deframer_if #(.DATA_BITS(8)) bus ();

    uart_rx_deframer #(
        .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2), .OVERSAMPLE(OS)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] err;
        logic       ovr;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n && bus.Wr_En === 1'b1) begin
            $display("write: data=%h err=%b ovr=%b cyc=%0d", bus.Wr_Data, bus.Rx_Error, bus.Overrun, cyc);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got data %h err %b, required no write", bus.Wr_Data, bus.Rx_Error);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wr_data", 32'(bus.Wr_Data), 32'(e.data));
                chk("rx_error", 32'(bus.Rx_Error), 32'(e.err));
                chk("overrun", 32'(bus.Overrun), 32'(e.ovr));
                chk("latency_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive_bit(input logic b);
        bus.Rx = b;
        repeat (OS) @(posedge Clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s0, input logic s1,
                              input logic [2:0] err, input logic ovr);
        exp_t e;
        e.data = d;
        e.err  = err;
        e.ovr  = ovr;
        e.cyc  = cyc + LAT;
        sbq.push_back(e);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(s0);
        drive_bit(s1);
    endtask

    initial begin
        exp_t e;
        bus.Sample_En = 1'b1;
        bus.Rx        = 1'b1;
        bus.FIFO_Full = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_wr_en", 32'(bus.Wr_En), 0);
        chk("rst_wr_data", 32'(bus.Wr_Data), 0);
        chk("rst_rx_error", 32'(bus.Rx_Error), 0);
        chk("rst_busy", 32'(bus.Rx_Busy), 0);
        chk("rst_overrun", 32'(bus.Overrun), 0);
        chk("rst_rts", 32'(bus.RTS), 0);
        Rst_n = 1'b1;
        idle_bits(1);
        chk("rts_idle", 32'(bus.RTS), 1);

        // clean frame followed back-to-back by another
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        idle_bits(2);

        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
        idle_bits(2);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
        idle_bits(2);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        idle_bits(2);

        // break: line low for 24 bit periods
        e.data = 8'h00; e.err = 3'b001; e.ovr = 1'b0; e.cyc = cyc + LAT;
        sbq.push_back(e);
        bus.Rx = 1'b0;
        repeat (24 * OS) @(posedge Clk);
        #1;
        idle_bits(3);

        // 4-tick glitch is a false start
        bus.Rx = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        bus.Rx = 1'b1;
        chk("glitch_busy_high", 32'(bus.Rx_Busy), 1);
        repeat (20) @(posedge Clk);
        #1;
        chk("glitch_busy_low", 32'(bus.Rx_Busy), 0);
        idle_bits(1);

        bus.FIFO_Full = 1'b1;
        @(posedge Clk);
        #1;
        chk("rts_full", 32'(bus.RTS), 0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1);
        bus.FIFO_Full = 1'b0;
        idle_bits(2);
        chk("rts_recovered", 32'(bus.RTS), 1);

        // reset after 5 data bits of 8'h5A
        drive_bit(1'b0);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        chk("busy_mid_frame", 32'(bus.Rx_Busy), 1);
        Rst_n  = 1'b0;
        bus.Rx = 1'b1;
        #2;
        chk("mid_rst_wr_en", 32'(bus.Wr_En), 0);
        chk("mid_rst_wr_data", 32'(bus.Wr_Data), 0);
        chk("mid_rst_rx_error", 32'(bus.Rx_Error), 0);
        chk("mid_rst_busy", 32'(bus.Rx_Busy), 0);
        chk("mid_rst_rts", 32'(bus.RTS), 0);
        repeat (3) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        idle_bits(2);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        idle_bits(2);

        for (int i = 0; i < 1000 && sbq.size() != 0; i++) @(posedge Clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: got %0d pending, required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
